mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Byte-serial memory controller between the instruction-fetch stage, the MEM stage and the 8-bit external RAM port.
- Arbitrates fetch and load/store requests onto one RAM port.
- Assembles and splits 32-bit little-endian words.
- Produces the if_stall and mem_stall inputs consumed by the pipeline stall controller.
- One clock (clk); reset (rst) is asynchronous and active-high.

Parameters:
ADDR_W, 32, width of all address buses
DATA_W, 32, width of fetch/load/store data words (fixed at 4 bytes)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch byte address
if_clear  in  1  abort in-flight fetch (branch redirect)
if_data  out  32  fetched instruction, valid when if_done=1
if_done  out  1  one-cycle fetch-complete pulse
mem_req  in  1  load/store request, held until mem_done
mem_we  in  1  1=store, 0=load
mem_len  in  2  00=byte, 01=half, 10=word (11 treated as word)
mem_addr  in  ADDR_W  load/store base byte address
mem_wdata  in  32  store data; low bytes used per mem_len
mem_rdata  out  32  load data, zero-extended, valid when mem_done=1
mem_done  out  1  one-cycle load/store-complete pulse
ram_din  in  8  RAM read byte, returns one cycle after address
ram_dout  out  8  RAM write byte
ram_a  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
if_stall  out  1  if_req & ~if_done
mem_stall  out  1  mem_req & ~mem_done

Behaviour:
- Reset: state=IDLE, cnt=0, latched base/len/wdata=0.
  - Outputs: if_data=0, mem_rdata=0, if_done=0, mem_done=0, ram_a=0, ram_dout=0, ram_wr=0.
  - Applies mid-transaction: the access is discarded and no done pulse is issued. Bytes already written to RAM remain.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE:
  - Samples requests each edge; priority mem_req over if_req.
  - Latches addr, N (1/2/4 bytes; IF always 4) and wdata; cnt<=0.
  - Moves to MEM_WR if mem_we, MEM_RD if not, or IF_RD for a fetch.
  - Outputs ram_a=0, ram_wr=0.
- Read (IF_RD/MEM_RD):
  - In the cycle with cnt=i (i<N): ram_a=base+i, ram_wr=0.
  - ram_din sampled at the edge ending cycle cnt=i+1 is byte i, stored at bits [8i+7:8i].
  - After the cnt=N cycle, go to DONE. Busy time is N+1 cycles.
- Write (MEM_WR):
  - In the cycle with cnt=i (i<N): ram_wr=1, ram_a=base+i, ram_dout=wdata[8i+7:8i].
  - After the cnt=N-1 cycle, go to DONE. Busy time is N cycles.
- DONE:
  - Exactly one cycle; asserts if_done or mem_done with data held valid.
  - Requests are ignored in this cycle (the requester drops req on the following edge); next state IDLE.
- Data formatting:
  - mem_rdata unused upper bytes = 0. Sign extension is done by the MEM stage.
  - if_data and mem_rdata hold their last value until overwritten.
- Address arithmetic: base+i is modulo 2^ADDR_W, so it wraps at 0xFFFFFFFF.
- Stalls are combinational from req/done.
  - A requester stays stalled while the other requester's transaction is in progress.
- if_clear:
  - High in IF_RD → next state IDLE, no if_done, if_data unchanged.
  - High in IDLE → the fetch is not accepted that edge.
  - High in DONE for a fetch → if_done is suppressed.
  - No effect on MEM transactions.
- A request change mid-transaction is ignored; the latched values are used.

Test Plan:
- Fetch if_addr=0x10, RAM[0x10..0x13]=13 05 10 00:
  - ram_a steps 0x10..0x13, then 5 busy cycles.
  - DONE cycle shows if_done=1, if_data=0x00100513.
  - if_stall=1 until that cycle.
- Store word 0xDEADBEEF at 0x100:
  - ram_wr=1 for 4 cycles with (a,dout)=(100,EF),(101,BE),(102,AD),(103,DE).
  - Then mem_done=1 for one cycle, ram_wr=0.
- Load byte at 0x200 with RAM=0x80 → mem_rdata=0x00000080, mem_done after 2 busy cycles. Load half at 0x1FF wraps nothing but spans 0x1FF/0x200 correctly.
- mem_req and if_req asserted the same cycle:
  - MEM transaction runs first with if_stall=1 throughout.
  - Fetch starts in the IDLE following mem DONE; both done pulses appear exactly once.
- if_clear pulsed during the IF_RD cnt=2 cycle → IDLE next cycle, no if_done, if_data unchanged; a new fetch then completes normally.
- rst asserted asynchronously mid MEM_WR (after 2 bytes):
  - All outputs are 0 immediately.
  - After release the controller accepts a new request from IDLE; bytes 0–1 remain written.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Byte-serial memory controller: arbitrates the fetch and load/store requesters
// onto one 8-bit RAM port. It assembles and splits 32-bit little-endian words
// and produces the stall signals for both pipeline stages.
module mem_bus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_clear,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              if_stall,
  output logic              mem_stall
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [2:0]        len_n;        // bytes in the latched transaction (1/2/4)
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rbuf, rbuf_nx; // read assembly buffer, cleared on accept
  logic              is_if;        // latched transaction belongs to fetch
  logic              accept_mem, accept_if;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state, RAM port drive and done pulses
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    rbuf_nx    = rbuf;
    ram_a      = '0;
    ram_wr     = 1'b0;
    ram_dout   = '0;
    if_done    = 1'b0;
    mem_done   = 1'b0;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (mem_req) begin
          accept_mem = 1'b1;
          state_nx   = mem_we ? MEM_WR : MEM_RD;
        end else if (if_req && !if_clear) begin
          accept_if = 1'b1;
          state_nx  = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        if (cnt < len_n) ram_a = base + ADDR_W'(cnt);
        // RAM answers one cycle late, so the byte arriving now is byte cnt-1
        for (int b = 0; b < NB; b++)
          if (cnt == 3'(b + 1)) rbuf_nx[8*b +: 8] = ram_din;
        if (state == IF_RD && if_clear) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == len_n) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      MEM_WR: begin
        ram_wr = 1'b1;
        ram_a  = base + ADDR_W'(cnt);
        for (int b = 0; b < NB; b++)
          if (cnt == 3'(b)) ram_dout = wdata[8*b +: 8];
        if (cnt == 3'(len_n - 3'd1)) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DONE: begin
        // A redirect arriving in the completion cycle kills the fetch pulse
        if_done  = is_if & ~if_clear;
        mem_done = ~is_if;
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Transaction latches, read assembly and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      len_n     <= '0;
      base      <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      is_if     <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      cnt <= cnt_nx;
      if (accept_mem) begin
        base  <= mem_addr;
        wdata <= mem_wdata;
        is_if <= 1'b0;
        rbuf  <= '0;
        case (mem_len)
          2'b00:   len_n <= 3'd1;
          2'b01:   len_n <= 3'd2;
          default: len_n <= 3'd4;
        endcase
      end else if (accept_if) begin
        base  <= if_addr;
        wdata <= '0;
        is_if <= 1'b1;
        rbuf  <= '0;
        len_n <= 3'd4;
      end else begin
        rbuf <= rbuf_nx;
      end
      // Publish the assembled word as the read enters DONE
      if (state_nx == DONE && state == IF_RD)  if_data   <= rbuf_nx;
      if (state_nx == DONE && state == MEM_RD) mem_rdata <= rbuf_nx;
    end
  end

  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a byte-wide RAM model (one-cycle read latency).
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_clear, if_done, mem_req, mem_we, mem_done;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_a;
  logic [1:0]  mem_len;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_wr, if_stall, mem_stall;

  bit   [7:0]  ram [0:1023];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [7:0]  pre_d;

  int errs = 0;
  int checks = 0;

  mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
    .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .if_stall(if_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write on strobe, preload port for the bench
  always @(posedge clk) begin
    ram_din <= ram[ram_a[9:0]];
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    if (pre_we) ram[pre_a] <= pre_d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue a load/store from IDLE, count negedges up to and including the done cycle
  task automatic mem_tx(input logic we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_cyc, input string tag);
    int cyc;
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_done && cyc < 20);
    chk(tag, cyc, exp_cyc);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic if_tx(input logic [31:0] addr, input int exp_cyc, input string tag);
    int cyc;
    if_req = 1'b1; if_addr = addr;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if_done && cyc < 20);
    chk(tag, cyc, exp_cyc);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_if, n_mem, c_if, c_mem, bad_stall;
    rst = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    if_req = 0; if_clear = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_len = 0; mem_addr = 0; mem_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_dout", ram_dout, 0);
    chk("rst_ram_wr", ram_wr, 0);

    poke(10'h010, 8'h13); poke(10'h011, 8'h05); poke(10'h012, 8'h10); poke(10'h013, 8'h00);
    poke(10'h020, 8'h44); poke(10'h021, 8'h33); poke(10'h022, 8'h22); poke(10'h023, 8'h11);
    poke(10'h200, 8'h80); poke(10'h1FF, 8'h34); poke(10'h3FF, 8'h5A); poke(10'h000, 8'hA5);
    rst = 1'b0;
    @(negedge clk);

    // Fetch at 0x10, cycle by cycle
    if_req = 1'b1; if_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fetch_ram_a", ram_a, 32'h10 + i);
      chk("fetch_stall", if_stall, 1);
    end
    @(negedge clk);
    chk("fetch_busy5_done", if_done, 0);
    chk("fetch_busy5_stall", if_stall, 1);
    @(negedge clk);
    chk("fetch_done", if_done, 1);
    chk("fetch_data", if_data, 32'h00100513);
    chk("fetch_done_stall", if_stall, 0);
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_done_pulse", if_done, 0);

    // Store word 0xDEADBEEF at 0x100, cycle by cycle
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_wr", ram_wr, 1);
      chk("st_a", ram_a, 32'h100 + i);
      chk("st_dout", ram_dout, (32'hDEADBEEF >> (8 * i)) & 32'hFF);
    end
    @(negedge clk);
    chk("st_done", mem_done, 1);
    chk("st_done_wr", ram_wr, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk("st_done_pulse", mem_done, 0);
    chk("st_ram", {ram[10'h103], ram[10'h102], ram[10'h101], ram[10'h100]}, 32'hDEADBEEF);

    // Loads: byte, half spanning 0x1FF/0x200, half wrapping at the top of memory
    mem_tx(1'b0, 2'b00, 32'h200, 32'h0, 3, "ldb_cyc");
    chk("ldb_data", mem_rdata, 32'h00000080);
    mem_tx(1'b0, 2'b01, 32'h1FF, 32'h0, 4, "ldh_cyc");
    chk("ldh_data", mem_rdata, 32'h00008034);
    mem_tx(1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 4, "ldwrap_cyc");
    chk("ldwrap_data", mem_rdata, 32'h0000A55A);

    // Store half only touches two bytes
    mem_tx(1'b1, 2'b01, 32'h300, 32'h12345678, 3, "sth_cyc");
    chk("sth_ram", {ram[10'h302], ram[10'h301], ram[10'h300]}, 32'h005678);

    // Simultaneous requests: load word first, then the fetch
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h10;
    n_if = 0; n_mem = 0; c_if = 0; c_mem = 0; bad_stall = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (n_mem == 0 && !mem_done && !if_stall) bad_stall++;
      if (mem_done) begin n_mem++; c_mem = c; mem_req = 1'b0; end
      if (if_done)  begin n_if++;  c_if = c;  if_req = 1'b0; end
    end
    chk("arb_mem_cnt", n_mem, 1);
    chk("arb_if_cnt", n_if, 1);
    chk("arb_mem_cyc", c_mem, 6);
    chk("arb_if_cyc", c_if, 13);
    chk("arb_if_stall", bad_stall, 0);
    chk("arb_mem_data", mem_rdata, 32'hDEADBEEF);
    chk("arb_if_data", if_data, 32'h00100513);

    // Redirect during IF_RD cnt=2, then clear held in IDLE blocks acceptance
    if_req = 1'b1; if_addr = 32'h20;
    repeat (3) @(negedge clk);
    if_clear = 1'b1;
    @(negedge clk);
    chk("clr_idle_a", ram_a, 0);
    chk("clr_no_done", if_done, 0);
    chk("clr_data_kept", if_data, 32'h00100513);
    @(negedge clk);
    chk("clr_not_accepted", ram_a, 0);
    if_clear = 1'b0;
    if_tx(32'h20, 6, "clr_refetch_cyc");
    chk("clr_refetch_data", if_data, 32'h11223344);

    // Redirect in the DONE cycle suppresses the pulse
    if_req = 1'b1; if_addr = 32'h10;
    repeat (6) @(negedge clk);
    chk("dclr_pre", if_done, 1);
    if_clear = 1'b1;
    #1;
    chk("dclr_suppr", if_done, 0);
    if_req = 1'b0;
    @(negedge clk);
    if_clear = 1'b0;
    @(negedge clk);

    // Asynchronous reset after two bytes of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h140; mem_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    chk("ars_pre_a", ram_a, 32'h142);
    rst = 1'b1;
    #1;
    chk("ars_wr", ram_wr, 0);
    chk("ars_a", ram_a, 0);
    chk("ars_dout", ram_dout, 0);
    chk("ars_rdata", mem_rdata, 0);
    chk("ars_ifdata", if_data, 0);
    chk("ars_done", mem_done, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ars_ram", {ram[10'h143], ram[10'h142], ram[10'h141], ram[10'h140]}, 32'h0000F00D);
    mem_tx(1'b0, 2'b00, 32'h141, 32'h0, 3, "ars_ld_cyc");
    chk("ars_ld_data", mem_rdata, 32'h000000F0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
